// File: rtl/serial_borrow_subtractor_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : serial_sub_pkg                                         |
// | Brief   : FSM state encoding and bit-index sizing helper for the |
// |           bit-serial borrow subtractor.                          |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that walks bit positions 0..w-1 (never narrower than 1).
  function automatic int idx_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_borrow_subtractor_fs.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : full_subtractor                                        |
// | Brief   : One-bit combinational full subtractor (a - b - bin).   |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow out of this position.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule
`default_nettype wire

// File: rtl/serial_borrow_subtractor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : serial_borrow_subtractor                               |
// | Brief   : Bit-serial unsigned subtractor, one bit per cycle from |
// |           the LSB, with valid/ready handshakes on both sides.    |
// |           Optional checker: define SERIAL_SUB_CHECK_EN to add a  |
// |           shadow copy of the operands and concurrent assertions. |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module serial_borrow_subtractor
  import serial_sub_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   diff,
  output logic [DATA_WIDTH-1:0] borrow_int
);

  localparam int                c_IDX_W    = idx_width(DATA_WIDTH);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_WIDTH - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [c_IDX_W-1:0]    r_idx;
  logic                  r_bin;
  logic [DATA_WIDTH-1:0] r_diff_lo;
  logic                  r_diff_msb;
  logic [DATA_WIDTH-1:0] r_borrow;
  logic                  w_d;
  logic                  w_bout;
  logic                  w_last;

  assign w_last     = (r_idx == c_LAST_IDX);
  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign diff       = {r_diff_msb, r_diff_lo};
  assign borrow_int = r_borrow;

  // Single shared bit slice, fed by the currently indexed operand bits.
  full_subtractor u_fs (
    .a    (r_a[r_idx]),
    .b    (r_b[r_idx]),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  // State register; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: accept in IDLE, walk all bits in RUN, hold result in DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then write one result bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_idx      <= '0;
      r_bin      <= 1'b0;
      r_diff_lo  <= '0;
      r_diff_msb <= 1'b0;
      r_borrow   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_idx      <= '0;
            r_bin      <= 1'b0;
            r_diff_lo  <= '0;
            r_diff_msb <= 1'b0;
            r_borrow   <= '0;
          end
        end
        RUN: begin
          r_diff_lo[r_idx] <= w_d;
          r_borrow[r_idx]  <= w_bout;
          r_bin            <= w_bout;
          r_idx            <= r_idx + c_IDX_ONE;
          if (w_last) r_diff_msb <= w_bout;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_CHECK_EN
  logic [DATA_WIDTH-1:0] r_a_shadow;
  logic [DATA_WIDTH-1:0] r_b_shadow;

  // Independent copy of the accepted operands for the result check.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_shadow <= '0;
      r_b_shadow <= '0;
    end else if (in_ready && in_valid) begin
      r_a_shadow <= a;
      r_b_shadow <= b;
    end
  end

  a_result_ok : assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (diff == ({1'b0, r_a_shadow} - {1'b0, r_b_shadow})));

  a_result_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> $stable(diff));

  a_hs_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(in_ready && out_valid));
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_borrow_subtractor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_serial_borrow_subtractor                            |
// | Brief   : Directed, table-driven bench for the serial subtractor |
// |           at DATA_WIDTH=8.                                       |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_serial_borrow_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   diff;
  logic [W-1:0] borrow_int;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   d;
    logic [W-1:0] bi;
  } vec_t;

  vec_t vecs[7];

  serial_borrow_subtractor #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_int (borrow_int)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a pair for one cycle, then count edges until out_valid (bounded).
  task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = ~va;
    b        = ~vb;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Accept the result and confirm the return to IDLE.
  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " in_ready after release"}, 64'(in_ready), 64'd1);
    check({tag, " out_valid after release"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int accepts;
    logic prev_ready;

    vecs[0] = '{8'h05, 8'h03, 9'h002, 8'h02};
    vecs[1] = '{8'h03, 8'h05, 9'h1FE, 8'hFC};
    vecs[2] = '{8'h00, 8'hFF, 9'h101, 8'hFF};
    vecs[3] = '{8'hFF, 8'hFF, 9'h000, 8'h00};
    vecs[4] = '{8'h80, 8'h01, 9'h07F, 8'h7F};
    vecs[5] = '{8'h10, 8'h20, 9'h1F0, 8'hE0};
    vecs[6] = '{8'h0A, 8'h0A, 9'h000, 8'h00};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset diff", 64'(diff), 64'd0);
    check("reset borrow_int", 64'(borrow_int), 64'd0);

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(W));
      check($sformatf("vec%0d diff", i), 64'(diff), 64'(vecs[i].d));
      check($sformatf("vec%0d borrow_int", i), 64'(borrow_int), 64'(vecs[i].bi));
      check($sformatf("vec%0d in_ready in DONE", i), 64'(in_ready), 64'd0);
      release_result($sformatf("vec%0d", i));
    end

    // Back-pressure: result held for 5 cycles with out_ready low.
    start_op(8'h05, 8'h03, lat);
    check("bp latency", 64'(lat), 64'(W));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp out_valid c%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("bp diff c%0d", k), 64'(diff), 64'h002);
      check($sformatf("bp borrow_int c%0d", k), 64'(borrow_int), 64'h02);
    end
    release_result("bp");

    // Reset on the 3rd RUN cycle aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'h03;
    b        = 8'h05;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst in_ready", 64'(in_ready), 64'd1);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst diff", 64'(diff), 64'd0);
    check("midrst borrow_int", 64'(borrow_int), 64'd0);
    start_op(8'h80, 8'h01, lat);
    check("postrst latency", 64'(lat), 64'(W));
    check("postrst diff", 64'(diff), 64'h07F);
    check("postrst borrow_int", 64'(borrow_int), 64'h7F);
    release_result("postrst");

    // Busy: in_valid held high and operands toggled during RUN.
    accepts    = 0;
    prev_ready = in_ready;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'h03;
    b        = 8'h05;
    @(posedge clk); #1;
    if (prev_ready && in_valid) accepts++;
    lat = 0;
    while (!out_valid && lat < 40) begin
      prev_ready = in_ready;
      @(negedge clk);
      a = a + 8'h37;
      b = b ^ 8'h5A;
      @(posedge clk); #1;
      if (prev_ready && in_valid) accepts++;
      lat++;
    end
    check("busy latency", 64'(lat), 64'(W));
    check("busy diff", 64'(diff), 64'h1FE);
    check("busy borrow_int", 64'(borrow_int), 64'hFC);
    check("busy accepts", 64'(accepts), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    release_result("busy");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
